mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource port among NUM_REQ requesters, e.g. the single memory port between the i-cache and d-cache refill engines and other masters.
- Arbitrates a request vector through a rotating-priority encode and holds a registered one-hot grant until the resource signals completion.
- Releases early if the requester withdraws or a watchdog timeout expires.
- Sits between the cache/requester FSMs and the memory interface.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one resource port among NUM_REQ requesters.
// Holds a registered one-hot grant until done, withdrawal or watchdog expiry.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       done,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]    ID_MOD   = (ID_W+1)'(NUM_REQ);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;

  logic               wd_hit;
  logic               release_now;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W-1:0]    arb_ptr;
  logic [NUM_REQ-1:0] arb_req;
  logic [2*NUM_REQ-1:0] dbl_req;
  logic               found;
  logic [ID_W:0]      win_off;
  logic [ID_W:0]      win_sum;
  logic [ID_W-1:0]    win_id;

  always_comb begin
    wd_hit      = (TIMEOUT != 0) && (cnt == CNT_LAST);
    release_now = (state == GRANTED) && (done || !req[grant_id] || wd_hit);
    next_ptr    = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
    // On release the old holder is excluded and the search starts just past it.
    arb_ptr     = release_now ? next_ptr : ptr;
    arb_req     = release_now ? (req & ~grant) : req;
    dbl_req     = {arb_req, arb_req} >> arb_ptr;
    found       = 1'b0;
    win_off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (dbl_req[k]) begin
        found   = 1'b1;
        win_off = (ID_W+1)'(k);
      end
    end
    win_sum = {1'b0, arb_ptr} + win_off;
    if (win_sum >= ID_MOD) begin
      win_sum = win_sum - ID_MOD;
    end
    win_id = win_sum[ID_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          cnt     <= '0;
          if (found) begin
            state       <= GRANTED;
            grant       <= NUM_REQ'(1) << win_id;
            grant_valid <= 1'b1;
            grant_id    <= win_id;
          end
        end
        GRANTED: begin
          if (release_now) begin
            // done outranks the watchdog as the reported release cause.
            timeout <= wd_hit && !done;
            ptr     <= next_ptr;
            cnt     <= '0;
            if (found) begin
              grant       <= NUM_REQ'(1) << win_id;
              grant_valid <= 1'b1;
              grant_id    <= win_id;
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_id    <= '0;
            end
          end else begin
            timeout <= 1'b0;
            if (cnt != {CNT_W{1'b1}}) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
          grant_id    <= '0;
          timeout     <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the round-robin rules.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         timeout;

  int vectors = 0;
  int fails   = 0;

  // Model state: holder index (-1 = none), rotating pointer, grant age, pulse.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit m_to     = 0;

  mem_port_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1; m_ptr = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d);
    int h, p, c, w;
    bit t, wd;
    logic [N-1:0] masked;
    h = m_holder; p = m_ptr; c = m_cnt; t = 0;
    if (h < 0) begin
      w = pick(r, p);
      if (w >= 0) begin h = w; c = 0; end
    end else begin
      wd = (TO != 0) && (c == TO - 1);
      if (d || !r[h] || wd) begin
        t = wd && !d;
        p = (h + 1) % N;
        masked = r;
        masked[h] = 1'b0;
        h = pick(masked, p);
        c = 0;
      end else begin
        c = (c < 65535) ? c + 1 : c;
      end
    end
    m_holder = h; m_ptr = p; m_cnt = c; m_to = t;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = (m_holder < 0) ? '0 : (N'(1) << m_holder);
    chk("grant",       32'(grant),       32'(eg));
    chk("grant_valid", 32'(grant_valid), 32'(m_holder >= 0));
    chk("grant_id",    32'(grant_id),    (m_holder < 0) ? 32'd0 : 32'(m_holder));
    chk("timeout",     32'(timeout),     32'(m_to));
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic d);
    req = r; done = d;
    model_step(r, d);
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic d;

    do_reset();

    // Single request, then done with nobody else waiting.
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b0);
    chk("single_id", 32'(grant_id), 32'd2);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b1);
    chk("single_release", 32'(grant), 32'd0);
    cycle(4'b0000, 1'b0);

    // Round robin from ptr=0 with done every third cycle.
    do_reset();
    cycle(4'b1111, 1'b0);
    chk("rr_first", 32'(grant_id), 32'd0);
    for (int g = 1; g <= 4; g++) begin
      cycle(4'b1111, 1'b0);
      cycle(4'b1111, 1'b0);
      cycle(4'b1111, 1'b1);
      chk("rr_next_id", 32'(grant_id), 32'(g % N));
      chk("rr_no_bubble", 32'(grant_valid), 32'd1);
    end
    cycle(4'b0000, 1'b1);

    // Lone holder keeps requesting after done: one idle cycle, then re-grant.
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    chk("mask_hold", 32'(grant_id), 32'd1);
    cycle(4'b0010, 1'b1);
    chk("mask_idle", 32'(grant_valid), 32'd0);
    cycle(4'b0010, 1'b0);
    chk("mask_regrant", 32'(grant_id), 32'd1);
    cycle(4'b0000, 1'b1);

    // Withdrawal hands over to a waiting requester without a timeout pulse.
    cycle(4'b0100, 1'b0);
    chk("wd_holder", 32'(grant_id), 32'd2);
    cycle(4'b0001, 1'b0);
    chk("withdraw_id", 32'(grant_id), 32'd0);
    chk("withdraw_to", 32'(timeout), 32'd0);
    cycle(4'b0000, 1'b0);

    // Watchdog expiry with a lone requester, then done on the expiry cycle.
    for (int i = 0; i < TO; i++) cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    chk("watchdog_pulse", 32'(timeout), 32'd1);
    chk("watchdog_release", 32'(grant), 32'd0);
    cycle(4'b0001, 1'b0);
    chk("watchdog_regrant", 32'(grant), 32'd1);
    for (int i = 1; i < TO; i++) cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b1);
    chk("done_beats_watchdog", 32'(timeout), 32'd0);
    cycle(4'b0000, 1'b0);

    // Random traffic: requests change occasionally so grants live long enough to expire.
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0);
      cycle(r, d);
    end

    // Asynchronous reset between edges while a grant is held.
    cycle(4'b0110, 1'b0);
    cycle(4'b0110, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_valid", 32'(grant_valid), 32'd0);
    chk("async_id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(4'b1000, 1'b0);
    chk("after_reset_id", 32'(grant_id), 32'd3);
    cycle(4'b1111, 1'b1);
    chk("after_reset_ptr", 32'(grant_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
